// File: rtl/rfphoenix_ictag_lru_pkg.sv
// Shared types for the instruction-cache tag array: sweep FSM states and tag entry layout.
package rfPhoenixPkg;

    // Widest tag any configuration stores; narrower tags are zero-extended into it.
    localparam int unsigned ICTAG_TAG_MAX_W = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } ictag_state_t;

    typedef struct packed {
        logic                       valid;
        logic [ICTAG_TAG_MAX_W-1:0] tag;
    } ictag_entry_t;

endpackage

// File: rtl/rfphoenix_ictag_repl.sv
// Per-set replacement state and victim selection for the tag array.
// ICTAG_PLRU_EN selects tree pseudo-LRU; otherwise round-robin per set.
module rfphoenix_ictag_repl #(
    parameter int unsigned LINES = 128,
    parameter int unsigned WAYS  = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [$clog2(LINES)-1:0] clr_idx,
    input  logic [$clog2(LINES)-1:0] lk_idx,
    output logic [$clog2(WAYS)-1:0]  lk_victim_c,
    input  logic [$clog2(LINES)-1:0] fill_idx,
    output logic [$clog2(WAYS)-1:0]  fill_victim_c,
    input  logic                     fill_upd,
    input  logic                     fill_new,
    input  logic [$clog2(WAYS)-1:0]  fill_way,
    input  logic                     hit_upd,
    input  logic [$clog2(LINES)-1:0] hit_idx,
    input  logic [$clog2(WAYS)-1:0]  hit_way
);

    localparam int unsigned WAYW = $clog2(WAYS);

`ifdef ICTAG_PLRU_EN
    // Tree node n (1..WAYS-1) lives at bit n-1; a bit of 0 points the victim left.
    logic [WAYS-2:0] plru_q [LINES];

    function automatic logic [WAYW-1:0] plru_victim(input logic [WAYS-2:0] b);
        int unsigned node;
        node = 1;
        for (int l = 0; l < int'(WAYW); l++) begin
            node = 2 * node + 32'(b[node-1]);
        end
        return WAYW'(node - WAYS);
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] b,
                                                   input logic [WAYW-1:0] way);
        logic [WAYS-2:0] r;
        int unsigned     node;
        r    = b;
        node = 1;
        for (int l = 0; l < int'(WAYW); l++) begin
            r[node-1] = ~way[WAYW-1-l];
            node      = 2 * node + 32'(way[WAYW-1-l]);
        end
        return r;
    endfunction

    assign lk_victim_c   = plru_victim(plru_q[lk_idx]);
    assign fill_victim_c = plru_victim(plru_q[fill_idx]);

    // Fill update is written last so it wins over a hit update to the same set.
    always_ff @(posedge clk) begin
        if (clr) begin
            plru_q[clr_idx] <= '0;
        end else begin
            if (hit_upd) plru_q[hit_idx] <= plru_touch(plru_q[hit_idx], hit_way);
            if (fill_upd) plru_q[fill_idx] <= plru_touch(plru_q[fill_idx], fill_way);
        end
    end

    logic unused_repl;
    assign unused_repl = fill_new;
`else
    logic [WAYW-1:0] rr_q [LINES];

    assign lk_victim_c   = rr_q[lk_idx];
    assign fill_victim_c = rr_q[fill_idx];

    // Only allocations into the victim way advance the pointer; refills of a resident line do not.
    always_ff @(posedge clk) begin
        if (clr) begin
            rr_q[clr_idx] <= '0;
        end else if (fill_upd && fill_new) begin
            rr_q[fill_idx] <= rr_q[fill_idx] + WAYW'(1);
        end
    end

    logic unused_repl;
    assign unused_repl = ^{fill_way, hit_upd, hit_idx, hit_way};
`endif

endmodule

// File: rtl/rfphoenix_ictag_lru.sv
// Instruction-cache tag array with lookup, fill, line/array invalidation and replacement.
// Define ICTAG_PLRU_EN for tree pseudo-LRU replacement instead of round-robin.
module rfphoenix_ictag_lru
    import rfPhoenixPkg::*;
#(
    parameter int unsigned LINES      = 128,
    parameter int unsigned WAYS       = 4,
    parameter int unsigned AWID       = 32,
    parameter int unsigned LINE_BYTES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic [AWID-1:0]         ip,
    output logic                    hit,
    output logic [$clog2(WAYS)-1:0] hit_way,
    output logic [$clog2(WAYS)-1:0] victim_way,
    input  logic                    fill,
    input  logic [AWID-1:0]         fill_adr,
    output logic                    fill_ack,
    input  logic                    inv_line,
    input  logic [AWID-1:0]         inv_adr,
    input  logic                    inv_all,
    output logic                    busy
);

    localparam int unsigned OFFW = $clog2(LINE_BYTES);
    localparam int unsigned IDXW = $clog2(LINES);
    localparam int unsigned WAYW = $clog2(WAYS);
    localparam int unsigned TAGW = AWID - OFFW - IDXW;

    ictag_state_t    state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic            sweep_c;
    logic            busy_q;
    logic            req_q;
    logic [IDXW-1:0] idx_q;
    logic [TAGW-1:0] tag_q;
    logic            fill_ack_q;

    ictag_entry_t tag_mem [WAYS][LINES];

    logic [IDXW-1:0] fill_idx, inv_idx;
    logic [TAGW-1:0] fill_tag;
    logic            fill_ok, inv_ok;
    logic            lk_hit_c, fill_hit_c;
    logic [WAYW-1:0] lk_way_c, fill_hit_way_c, fill_way_c;
    logic [WAYW-1:0] lk_victim_c, fill_victim_c;

    assign fill_idx = fill_adr[OFFW +: IDXW];
    assign fill_tag = fill_adr[AWID-1 -: TAGW];
    assign inv_idx  = inv_adr[OFFW +: IDXW];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ip[OFFW-1:0], fill_adr[OFFW-1:0], inv_adr[OFFW-1:0],
                                inv_adr[AWID-1 -: TAGW]};

    // inv_all in the same cycle also drops a fill: the sweep is about to clear it anyway.
    assign fill_ok = fill && !busy_q && !inv_line && !inv_all;
    assign inv_ok  = inv_line && !busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SWEEP;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            req_q      <= 1'b0;
            idx_q      <= '0;
            tag_q      <= '0;
            fill_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= (state_d == SWEEP);
            req_q      <= req && !busy_q;
            idx_q      <= req ? ip[OFFW +: IDXW] : idx_q;
            tag_q      <= req ? ip[AWID-1 -: TAGW] : tag_q;
            fill_ack_q <= fill_ok;
        end
    end

    // Sweep FSM: one set cleared per cycle, LINES cycles total.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sweep_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (inv_all) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                sweep_c = 1'b1;
                cnt_d   = cnt_q + IDXW'(1);
                if (cnt_q == IDXW'(LINES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag match for the registered lookup and for the incoming fill.
    always_comb begin
        lk_hit_c       = 1'b0;
        lk_way_c       = '0;
        fill_hit_c     = 1'b0;
        fill_hit_way_c = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (tag_mem[w][idx_q].valid &&
                tag_mem[w][idx_q].tag == ICTAG_TAG_MAX_W'(tag_q)) begin
                lk_hit_c = 1'b1;
                lk_way_c = WAYW'(w);
            end
            if (tag_mem[w][fill_idx].valid &&
                tag_mem[w][fill_idx].tag == ICTAG_TAG_MAX_W'(fill_tag)) begin
                fill_hit_c     = 1'b1;
                fill_hit_way_c = WAYW'(w);
            end
        end
    end

    assign fill_way_c = fill_hit_c ? fill_hit_way_c : fill_victim_c;

    always_ff @(posedge clk) begin
        if (sweep_c) begin
            for (int w = 0; w < int'(WAYS); w++) tag_mem[w][cnt_q].valid <= 1'b0;
        end else begin
            if (inv_ok) begin
                for (int w = 0; w < int'(WAYS); w++) tag_mem[w][inv_idx].valid <= 1'b0;
            end
            if (fill_ok) begin
                tag_mem[fill_way_c][fill_idx] <= '{valid: 1'b1,
                                                   tag: ICTAG_TAG_MAX_W'(fill_tag)};
            end
        end
    end

    assign hit        = req_q && !busy_q && lk_hit_c;
    assign hit_way    = hit ? lk_way_c : '0;
    assign victim_way = req_q ? lk_victim_c : '0;
    assign fill_ack   = fill_ack_q;
    assign busy       = busy_q;

    rfphoenix_ictag_repl #(
        .LINES (LINES),
        .WAYS  (WAYS)
    ) u_repl (
        .clk           (clk),
        .clr           (sweep_c),
        .clr_idx       (cnt_q),
        .lk_idx        (idx_q),
        .lk_victim_c   (lk_victim_c),
        .fill_idx      (fill_idx),
        .fill_victim_c (fill_victim_c),
        .fill_upd      (fill_ok),
        .fill_new      (!fill_hit_c),
        .fill_way      (fill_way_c),
        .hit_upd       (hit && !(fill_ok && fill_idx == idx_q)),
        .hit_idx       (idx_q),
        .hit_way       (lk_way_c)
    );

endmodule

// File: tb/tb_rfphoenix_ictag_lru.sv
// Directed vector bench for rfphoenix_ictag_lru (default parameters).
module tb_rfphoenix_ictag_lru;

    localparam int K_REQ     = 0;
    localparam int K_FILL    = 1;
    localparam int K_INV     = 2;
    localparam int K_FILLINV = 3;
    localparam int NV        = 26;

    typedef struct {
        int          kind;
        logic [31:0] adr;
        logic        exp_hit;
        logic [1:0]  exp_way;
        logic [1:0]  exp_victim;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, fill, inv_line, inv_all;
    logic [31:0] ip, fill_adr, inv_adr;
    logic        hit, fill_ack, busy;
    logic [1:0]  hit_way, victim_way;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs [NV];

    rfphoenix_ictag_lru dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ip         (ip),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way),
        .fill       (fill),
        .fill_adr   (fill_adr),
        .fill_ack   (fill_ack),
        .inv_line   (inv_line),
        .inv_adr    (inv_adr),
        .inv_all    (inv_all),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] adr(input int tag, input int set);
        return (32'(tag) << 13) | (32'(set) << 6);
    endfunction

    // Expected value under round-robin vs pseudo-LRU builds.
    function automatic int pick(input int rr, input int pl);
`ifdef ICTAG_PLRU_EN
        return pl;
`else
        return rr;
`endif
    endfunction

    function automatic vec_t mk(input int kind, input logic [31:0] a, input int h,
                                input int w, input int v);
        vec_t r;
        r.kind       = kind;
        r.adr        = a;
        r.exp_hit    = 1'(h);
        r.exp_way    = 2'(w);
        r.exp_victim = 2'(v);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until busy drops, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req = 1'b0; fill = 1'b0; inv_line = 1'b0; inv_all = 1'b0;
        ip = '0; fill_adr = '0; inv_adr = '0;

        vecs[0]  = mk(K_REQ,  32'h1000, 0, 0, 0);
        vecs[1]  = mk(K_FILL, 32'h1040, 0, 0, 0);
        vecs[2]  = mk(K_REQ,  32'h1040, 1, 0, pick(1, 2));
        vecs[3]  = mk(K_REQ,  32'h3040, 0, 0, pick(1, 2));
        vecs[4]  = mk(K_FILL, 32'h1040, 0, 0, 0);
        vecs[5]  = mk(K_REQ,  32'h3040, 0, 0, pick(1, 2));
        vecs[6]  = mk(K_REQ,  32'h1040, 1, 0, pick(1, 2));
        vecs[7]  = mk(K_FILL, adr(1, 1), 0, 0, 0);
        vecs[8]  = mk(K_FILL, adr(2, 1), 0, 0, 0);
        vecs[9]  = mk(K_FILL, adr(3, 1), 0, 0, 0);
        vecs[10] = mk(K_FILL, adr(4, 1), 0, 0, 0);
        vecs[11] = mk(K_REQ,  adr(1, 1), 1, 0, 0);
        vecs[12] = mk(K_REQ,  adr(2, 1), 1, pick(1, 2), pick(0, 2));
        vecs[13] = mk(K_REQ,  adr(9, 1), 0, 0, pick(0, 1));
        vecs[14] = mk(K_FILL, adr(5, 1), 0, 0, 0);
        vecs[15] = mk(K_REQ,  adr(5, 1), 1, pick(0, 1), pick(1, 3));
        vecs[16] = mk(K_REQ,  adr(1, 1), pick(0, 1), 0, pick(1, 3));
        vecs[17] = mk(K_REQ,  adr(3, 1), pick(1, 0), 2, pick(1, 3));
        vecs[18] = mk(K_FILL, adr(7, 2), 0, 0, 0);
        vecs[19] = mk(K_FILL, adr(8, 2), 0, 0, 0);
        vecs[20] = mk(K_INV,  32'h1040, 0, 0, 0);
        vecs[21] = mk(K_REQ,  32'h1040, 0, 0, pick(1, 2));
        vecs[22] = mk(K_REQ,  adr(7, 2), 1, 0, pick(2, 1));
        vecs[23] = mk(K_REQ,  adr(8, 2), 1, pick(1, 2), pick(2, 3));
        vecs[24] = mk(K_FILLINV, adr(3, 5), 0, 0, 0);
        vecs[25] = mk(K_REQ,  adr(3, 5), 0, 0, 0);

        // Reset state, then the power-on sweep length.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 1);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_fill_ack", 32'(fill_ack), 0);
        chk("rst_victim", 32'(victim_way), 0);
        rst_n = 1'b1;
        count_busy(n);
        chk("init_sweep_len", n, 128);

        for (int i = 0; i < NV; i++) begin
            case (vecs[i].kind)
                K_REQ: begin
                    req = 1'b1; ip = vecs[i].adr;
                    tick();
                    req = 1'b0;
                    chk($sformatf("v%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
                    if (vecs[i].exp_hit)
                        chk($sformatf("v%0d_hit_way", i), 32'(hit_way), 32'(vecs[i].exp_way));
                    chk($sformatf("v%0d_victim", i), 32'(victim_way), 32'(vecs[i].exp_victim));
                    tick();
                    chk($sformatf("v%0d_hit_idle", i), 32'(hit), 0);
                end
                K_FILL: begin
                    fill = 1'b1; fill_adr = vecs[i].adr;
                    tick();
                    fill = 1'b0;
                    chk($sformatf("v%0d_ack", i), 32'(fill_ack), 1);
                    tick();
                    chk($sformatf("v%0d_ack_pulse", i), 32'(fill_ack), 0);
                end
                K_INV: begin
                    inv_line = 1'b1; inv_adr = vecs[i].adr;
                    tick();
                    inv_line = 1'b0;
                    tick();
                end
                default: begin
                    fill = 1'b1; fill_adr = vecs[i].adr;
                    inv_line = 1'b1; inv_adr = adr(0, 6);
                    tick();
                    fill = 1'b0; inv_line = 1'b0;
                    chk($sformatf("v%0d_no_ack", i), 32'(fill_ack), 0);
                    tick();
                end
            endcase
        end

        // inv_all together with a fill; re-trigger and a lookup during the sweep are ignored.
        inv_all = 1'b1; fill = 1'b1; fill_adr = adr(6, 6);
        tick();
        inv_all = 1'b0; fill = 1'b0;
        chk("invall_no_ack", 32'(fill_ack), 0);
        chk("invall_busy", 32'(busy), 1);
        n = 0;
        while (busy && n < 400) begin
            inv_all = (n == 10);
            req     = (n == 20);
            ip      = adr(7, 2);
            tick();
            n++;
            inv_all = 1'b0; req = 1'b0;
            if (n == 21) chk("req_while_busy", 32'(hit), 0);
        end
        chk("invall_sweep_len", n, 128);

        for (int i = 0; i < 3; i++) begin
            req = 1'b1;
            ip  = (i == 0) ? adr(7, 2) : (i == 1) ? adr(5, 1) : adr(6, 6);
            tick();
            req = 1'b0;
            chk($sformatf("post_sweep%0d_hit", i), 32'(hit), 0);
            chk($sformatf("post_sweep%0d_victim", i), 32'(victim_way), 0);
            tick();
        end

        // Reset asserted 50 cycles into a sweep restarts it for a full LINES cycles.
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        repeat (50) tick();
        chk("mid_sweep_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_busy", 32'(busy), 1);
        chk("mid_rst_fill_ack", 32'(fill_ack), 0);
        tick();
        rst_n = 1'b1;
        count_busy(n);
        chk("rst_restart_len", n, 128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
